// File: rtl/fadd_share_arb.sv
// Round-robin scheduler sharing one pipelined float_add.
// Tags each issue and returns sums to the issuing requester.
module fadd_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_v1,
  input  logic [NREQ*32-1:0] req_v2,
  output logic [31:0]       fa_v1,
  output logic [31:0]       fa_v2,
  input  logic [31:0]       fa_res,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_res,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   r_ptr;
  logic [31:0]     r_v1;
  logic [31:0]     r_v2;
  logic [LAT-1:0]  r_tv;
  logic [IW-1:0]   r_ti [LAT];
  logic [NREQ-1:0] r_rsp_v;
  logic [31:0]     r_rsp_res;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [IW-1:0]   w_nxt;
  int              w_j;

  // Priority search from r_ptr, wrapping modulo NREQ
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_any && req_valid[w_j[IW-1:0]]) begin
        w_any = 1'b1;
        w_gnt[w_j[IW-1:0]] = 1'b1;
        w_idx = w_j[IW-1:0];
      end
    end
    if (rst) begin
      w_gnt = '0;
      w_any = 1'b0;
    end
  end

  // Pointer moves just past the winner
  always_comb begin
    w_nxt = '0;
    if (int'(w_idx) != NREQ - 1) w_nxt = w_idx + 1'b1;
  end

  // Issue register: operands and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_v1  <= '0;
      r_v2  <= '0;
    end else if (w_any) begin
      r_ptr <= w_nxt;
      r_v1  <= req_v1[32*w_idx +: 32];
      r_v2  <= req_v2[32*w_idx +: 32];
    end
  end

  // Tag delay line matched to adder latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tv <= '0;
      for (int s = 0; s < LAT; s++) r_ti[s] <= '0;
    end else begin
      r_tv[0] <= w_any;
      r_ti[0] <= w_idx;
      for (int s = 1; s < LAT; s++) begin
        r_tv[s] <= r_tv[s-1];
        r_ti[s] <= r_ti[s-1];
      end
    end
  end

  // Response pulse and captured sum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_v   <= '0;
      r_rsp_res <= '0;
    end else if (r_tv[LAT-1]) begin
      r_rsp_v   <= {{(NREQ-1){1'b0}}, 1'b1} << r_ti[LAT-1];
      r_rsp_res <= fa_res;
    end else begin
      r_rsp_v   <= '0;
    end
  end

  assign req_ready = w_gnt;
  assign fa_v1     = r_v1;
  assign fa_v2     = r_v2;
  assign rsp_valid = r_rsp_v;
  assign rsp_res   = r_rsp_res;
  assign busy      = (|r_tv) | (|r_rsp_v);

endmodule

// File: tb/tb_fadd_share_arb.sv
// Directed bench for fadd_share_arb with a
// behavioural 3-edge float_add model.
module tb_fadd_share_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_v1;
  logic [127:0] req_v2;
  logic [31:0]  fa_v1;
  logic [31:0]  fa_v2;
  logic [31:0]  fa_res;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_res;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] s1, s2;
  logic [31:0] sums [4];
  logic [3:0]  exp4;

  always #5 clk = ~clk;

  fadd_share_arb #(.NREQ(4), .LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_v1(req_v1), .req_v2(req_v2),
    .fa_v1(fa_v1), .fa_v2(fa_v2), .fa_res(fa_res),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res),
    .busy(busy)
  );

  // Positive normals only; exponent 0xFF passes operand 1 through
  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [7:0]  ea, d;
    logic [23:0] ma, mb;
    logic [24:0] s;
    logic [31:0] t;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] > a[30:23]) begin
      t = a; a = b; b = t;
    end
    ea = a[30:23];
    d  = a[30:23] - b[30:23];
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    mb = (d > 8'd23) ? 24'd0 : (mb >> d);
    s  = {1'b0, ma} + {1'b0, mb};
    if (s[24]) return {a[31], ea + 8'd1, s[23:1]};
    return {a[31], ea, s[22:0]};
  endfunction

  // Behavioural adder: sampled LAT edges after operand load
  always @(posedge clk) begin
    s1 <= fadd(fa_v1, fa_v2);
    s2 <= s1;
  end
  assign fa_res = s2;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i,
                        input logic [31:0] a,
                        input logic [31:0] b);
    req_v1[32*i +: 32] = a;
    req_v2[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    sums[0] = 32'h40000000;
    sums[1] = 32'h40800000;
    sums[2] = 32'h40400000;
    sums[3] = 32'h41000000;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_v1 = '0;
    req_v2 = '0;
    tick();
    #1;
    chk("rdy_in_rst", {28'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("rst_fa_v1", fa_v1, 32'd0);
    chk("rst_fa_v2", fa_v2, 32'd0);
    chk("rst_rsp_v", {28'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single request from requester 2
    set_op(2, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0100;
    #1;
    chk("single_rdy", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_fa_v1", fa_v1, 32'h3F800000);
    chk("single_fa_v2", fa_v2, 32'h40000000);
    chk("single_busy0", {31'd0, busy}, 32'd1);
    tick();
    chk("single_rsp_e1", {28'd0, rsp_valid}, 32'd0);
    tick();
    chk("single_rsp_e2", {28'd0, rsp_valid}, 32'd0);
    chk("single_busy2", {31'd0, busy}, 32'd1);
    tick();
    chk("single_rsp_v", {28'd0, rsp_valid}, 32'h4);
    chk("single_rsp_res", rsp_res, 32'h40400000);
    chk("single_busy3", {31'd0, busy}, 32'd1);
    tick();
    chk("single_rsp_off", {28'd0, rsp_valid}, 32'd0);
    chk("single_busy4", {31'd0, busy}, 32'd0);
    chk("single_hold", rsp_res, 32'h40400000);

    // Full load, pointer restarted at 0
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h3F800000, 32'h40000000);
    set_op(3, 32'h40800000, 32'h40800000);
    req_valid = 4'b1111;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = 4'b0000;
      #1;
      exp4 = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      chk($sformatf("full_rdy%0d", k), {28'd0, req_ready}, {28'd0, exp4});
      tick();
      if (k >= 3) begin
        exp4 = 4'b0001 << ((k - 3) % 4);
        chk($sformatf("full_rsp_v%0d", k - 3),
            {28'd0, rsp_valid}, {28'd0, exp4});
        chk($sformatf("full_rsp_res%0d", k - 3),
            rsp_res, sums[(k - 3) % 4]);
      end
    end
    tick();
    chk("full_drain", {28'd0, rsp_valid}, 32'd0);

    // Sparse fairness: requesters 1 and 3
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp4 = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      chk($sformatf("sparse_rdy%0d", k), {28'd0, req_ready}, {28'd0, exp4});
      tick();
    end
    req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) tick();

    // Reset mid-flight: two issues from requester 0
    set_op(0, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0001;
    tick();
    set_op(0, 32'h40000000, 32'h40000000);
    tick();
    req_valid = 4'b0000;
    do_reset();
    #1;
    chk("mid_fa_v1", fa_v1, 32'd0);
    chk("mid_fa_v2", fa_v2, 32'd0);
    chk("mid_rsp_res", rsp_res, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_rsp_v%0d", k), {28'd0, rsp_valid}, 32'd0);
      tick();
    end
    req_valid = 4'b0011;
    #1;
    chk("mid_next_rdy", {28'd0, req_ready}, 32'h1);
    req_valid = 4'b0000;
    #1;

    // Idle hold and NaN pass-through
    set_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("idle_v1_%0d", j), fa_v1, 32'hFFFFFFFF);
      chk($sformatf("idle_v2_%0d", j), fa_v2, 32'hFFFFFFFF);
      chk($sformatf("idle_rdy_%0d", j), {28'd0, req_ready}, 32'd0);
      tick();
      if (j == 2) begin
        chk("nan_rsp_v", {28'd0, rsp_valid}, 32'h1);
        chk("nan_rsp_res", rsp_res, 32'hFFFFFFFF);
      end
    end

    // Withdrawn request from 0 while 3 holds the grant
    set_op(3, 32'h40800000, 32'h40800000);
    req_valid = 4'b1001;
    #1;
    chk("wd_rdy", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("wd_rdy_after", {28'd0, req_ready}, 32'd0);
    tick();
    tick();
    tick();
    chk("wd_rsp_v", {28'd0, rsp_valid}, 32'h8);
    chk("wd_rsp_res", rsp_res, 32'h41000000);
    tick();
    chk("wd_rsp_none", {28'd0, rsp_valid}, 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("wd_ptr", {28'd0, req_ready}, 32'h1);
    req_valid = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
